// File: rtl/adc_scanner_if.sv
// adc_scanner_if: pin and host bundle for adc_scanner.
//   SPI side : sck, cs_n, dout (scanner -> ADC), din (ADC -> scanner)
//   Host side: enable, addr, ack (host -> scanner);
//              q, changed, irq, sample_tick, sample_ch (scanner -> host)
// master is the scanner; slave is the surrounding logic / ADC.
`timescale 1ns/1ps
interface adc_scanner_if #(
    parameter int ADC_WIDTH = 8,
    parameter int NUM_CH    = 8
);
    logic                 enable;
    logic                 sck;
    logic                 cs_n;
    logic                 dout;
    logic                 din;
    logic [2:0]           addr;
    logic [ADC_WIDTH-1:0] q;
    logic                 ack;
    logic [NUM_CH-1:0]    changed;
    logic                 irq;
    logic                 sample_tick;
    logic [2:0]           sample_ch;

    modport master (
        input  enable, din, addr, ack,
        output sck, cs_n, dout, q, changed, irq, sample_tick, sample_ch
    );

    modport slave (
        output enable, din, addr, ack,
        input  sck, cs_n, dout, q, changed, irq, sample_tick, sample_ch
    );
endinterface

// File: rtl/adc_scanner.sv
// adc_scanner: scans NUM_CH channels of an ADCx8S102-class SPI ADC, one
// CS-delimited 16-bit frame per channel, smooths each channel with a
// first-order IIR filter and raises sticky per-channel change flags.
// Ports:
//   clk   - system clock; SCK is derived from it (CLK_DIV clks per half)
//   reset - synchronous, active-high, dominant
//   bus   - adc_scanner_if.master (SPI pins, read port, flags, tick)
// The conversion returned in a frame belongs to the channel addressed in
// the previous frame, so the first frame after start-up is discarded.
`timescale 1ns/1ps
module adc_scanner #(
    parameter int ADC_WIDTH    = 8,
    parameter int NUM_CH       = 8,
    parameter int CLK_DIV      = 1,
    parameter int CS_GAP       = 4,
    parameter int FILTER_SHIFT = 2,
    parameter int THRESH       = 2
) (
    input  logic          clk,
    input  logic          reset,
    adc_scanner_if.master bus
);
    localparam int PW      = ADC_WIDTH + 2;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD  = (CS_GAP >= 2) ? CW'(CS_GAP - 2) : '0;
    // Frame bit positions (MSB first) that carry the sample field 11 -: ADC_WIDTH
    localparam logic [3:0] CAP_LO = 4'd4;
    localparam logic [3:0] CAP_HI = 4'(3 + ADC_WIDTH);
    localparam logic signed [PW-1:0] MAXV = PW'((1 << ADC_WIDTH) - 1);
    localparam logic signed [PW-1:0] THR  = PW'(THRESH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, UPDATE, GAP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bitn;
    logic [15:0]          tx;
    logic [ADC_WIDTH-1:0] rx;
    logic [2:0]           nxt, pend;
    logic                 prime;

    logic                 sck_r, cs_r, dout_r, irq_r, tick_r;
    logic [2:0]           tch_r;
    logic [ADC_WIDTH-1:0] q_r;
    logic [NUM_CH-1:0]    chg;

    logic [ADC_WIDTH-1:0] f_mem   [NUM_CH];
    logic [ADC_WIDTH-1:0] ref_mem [NUM_CH];
    logic [NUM_CH-1:0]    seeded;

    logic [2:0]           nxt_adv, frame_ch;
    logic                 gap_done;
    logic [ADC_WIDTH-1:0] f_old, ref_old, q_next, f_new;
    logic signed [PW-1:0] diff, step, f_sum, delta, mag;
    logic                 over;

    assign nxt_adv  = (nxt == 3'(NUM_CH - 1)) ? 3'd0 : nxt + 3'd1;
    // When the gap is a single clk the next frame starts straight out of
    // UPDATE, where nxt has not yet advanced.
    assign frame_ch = (state == UPDATE) ? nxt_adv : nxt;
    assign gap_done = (state == GAP && cnt == '0) || (state == UPDATE && CS_GAP == 1);

    always_comb begin
        f_old   = '0;
        ref_old = '0;
        q_next  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend == 3'(i)) begin
                f_old   = f_mem[i];
                ref_old = ref_mem[i];
            end
            if (bus.addr == 3'(i)) q_next = f_mem[i];
        end
    end

    // IIR step in ADC_WIDTH+2 signed bits, clamped back to the sample range.
    assign diff  = $signed({2'b00, rx}) - $signed({2'b00, f_old});
    assign step  = diff >>> FILTER_SHIFT;
    assign f_sum = $signed({2'b00, f_old}) + step;
    assign f_new = f_sum[PW-1] ? '0 : (f_sum > MAXV) ? '1 : f_sum[ADC_WIDTH-1:0];
    assign delta = $signed({2'b00, f_new}) - $signed({2'b00, ref_old});
    assign mag   = delta[PW-1] ? -delta : delta;
    assign over  = (mag >= THR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitn   <= '0;
            tx     <= '0;
            rx     <= '0;
            nxt    <= '0;
            pend   <= '0;
            prime  <= 1'b1;
            sck_r  <= 1'b1;
            cs_r   <= 1'b1;
            dout_r <= 1'b0;
            irq_r  <= 1'b0;
            tick_r <= 1'b0;
            tch_r  <= '0;
            q_r    <= '0;
            chg    <= '0;
            seeded <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                f_mem[i]   <= '0;
                ref_mem[i] <= '0;
            end
        end else begin
            tick_r <= 1'b0;
            irq_r  <= |chg;
            q_r    <= q_next;

            // ack first so a flag set in the same clk overrides the clear
            if (bus.ack)
                for (int i = 0; i < NUM_CH; i++)
                    if (bus.addr == 3'(i)) chg[i] <= 1'b0;

            case (state)
                IDLE: begin
                    cs_r  <= 1'b1;
                    sck_r <= 1'b1;
                end
                SETUP: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        state  <= SHIFT;
                        sck_r  <= 1'b0;
                        dout_r <= tx[15];
                        tx     <= {tx[14:0], 1'b0};
                        bitn   <= '0;
                        cnt    <= HALF_LD;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!sck_r) begin
                        sck_r <= 1'b1;
                        cnt   <= HALF_LD;
                        // only the sample field is kept; the rest of the word is ignored
                        if (bitn >= CAP_LO && bitn <= CAP_HI)
                            rx <= {rx[ADC_WIDTH-2:0], bus.din};
                    end else if (bitn == 4'd15) begin
                        state  <= UPDATE;
                        cs_r   <= 1'b1;
                        dout_r <= 1'b0;
                    end else begin
                        sck_r  <= 1'b0;
                        dout_r <= tx[15];
                        tx     <= {tx[14:0], 1'b0};
                        bitn   <= bitn + 4'd1;
                        cnt    <= HALF_LD;
                    end
                end
                UPDATE: begin
                    cs_r  <= 1'b1;
                    sck_r <= 1'b1;
                    if (prime) prime <= 1'b0;
                    else begin
                        tick_r <= 1'b1;
                        tch_r  <= pend;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (pend == 3'(i)) begin
                                if (!seeded[i]) begin
                                    f_mem[i]   <= rx;
                                    ref_mem[i] <= rx;
                                    seeded[i]  <= 1'b1;
                                end else begin
                                    f_mem[i] <= f_new;
                                    if (over) begin
                                        chg[i]     <= 1'b1;
                                        ref_mem[i] <= f_new;
                                    end
                                end
                            end
                        end
                    end
                    pend  <= nxt;
                    nxt   <= nxt_adv;
                    state <= GAP;
                    cnt   <= GAP_LD;
                end
                GAP: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Frame start / stop decisions override the per-state updates above.
            if ((state == IDLE || gap_done) && bus.enable) begin
                state <= SETUP;
                cs_r  <= 1'b0;
                sck_r <= 1'b1;
                cnt   <= HALF_LD;
                tx    <= {2'b00, frame_ch, 11'b0};
            end else if (gap_done) begin
                state <= IDLE;
                prime <= 1'b1;
            end
        end
    end

    assign bus.sck         = sck_r;
    assign bus.cs_n        = cs_r;
    assign bus.dout        = dout_r;
    assign bus.q           = q_r;
    assign bus.changed     = chg;
    assign bus.irq         = irq_r;
    assign bus.sample_tick = tick_r;
    assign bus.sample_ch   = tch_r;
endmodule

// File: tb/tb_adc_scanner.sv
`timescale 1ns/1ps
module tb_adc_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en;
    logic [15:0] chan_val [8];

    adc_scanner_if #(.ADC_WIDTH(8),  .NUM_CH(8)) b0();
    adc_scanner_if #(.ADC_WIDTH(12), .NUM_CH(3)) b1();

    adc_scanner #(.ADC_WIDTH(8), .NUM_CH(8), .CLK_DIV(1), .CS_GAP(4),
                  .FILTER_SHIFT(2), .THRESH(2))
        dut0 (.clk(clk), .reset(reset), .bus(b0.master));
    adc_scanner #(.ADC_WIDTH(12), .NUM_CH(3), .CLK_DIV(2), .CS_GAP(4),
                  .FILTER_SHIFT(2), .THRESH(2))
        dut1 (.clk(clk), .reset(reset), .bus(b1.master));

    int n_chk = 0, n_fail = 0;
    int cyc = 0, tick_cnt = 0, pulses0 = 0;
    logic [15:0] adc_sh0 = '0, ctl0 = '0, ctl1 = '0;
    logic p_sck0 = 1'b1, p_cs0 = 1'b1, p_sck1 = 1'b1, p_cs1 = 1'b1;
    logic [2:0] last_addr0 = '0;
    int cs_fall0[$], cs_fall1[$], pulse_log0[$], tick_cyc[$];
    logic [15:0] ctl_log0[$], ctl_log1[$];
    logic [2:0] tick_ch[$];

    // ADC model for dut0: returns the word of the channel addressed in the
    // previous frame, MSB first, advancing after each SCK rise.
    assign b0.din    = adc_sh0[15];
    assign b1.din    = 1'b1;
    assign b0.enable = en;
    assign b1.enable = en;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_sck0 <= b0.sck;
        p_cs0  <= b0.cs_n;
        p_sck1 <= b1.sck;
        p_cs1  <= b1.cs_n;
        if (b0.cs_n) adc_sh0 <= chan_val[last_addr0];
        else if (b0.sck && !p_sck0) adc_sh0 <= adc_sh0 << 1;
        if (b0.sck && !p_sck0 && !b0.cs_n) begin
            ctl0    <= {ctl0[14:0], b0.dout};
            pulses0 <= pulses0 + 1;
        end
        if (!b0.cs_n && p_cs0) begin
            cs_fall0.push_back(cyc);
            pulses0 <= 0;
        end
        if (b0.cs_n && !p_cs0) begin
            ctl_log0.push_back(ctl0);
            pulse_log0.push_back(pulses0);
            last_addr0 <= ctl0[13:11];
        end
        if (b0.sample_tick) begin
            tick_cnt <= tick_cnt + 1;
            tick_cyc.push_back(cyc);
            tick_ch.push_back(b0.sample_ch);
        end
        if (b1.sck && !p_sck1 && !b1.cs_n) ctl1 <= {ctl1[14:0], b1.dout};
        if (!b1.cs_n && p_cs1) cs_fall1.push_back(cyc);
        if (b1.cs_n && !p_cs1) ctl_log1.push_back(ctl1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd0(input logic [2:0] a, input logic [31:0] exp);
        b0.addr = a;
        @(negedge clk);
        check($sformatf("q0_addr%0d", a), b0.q, exp);
    endtask

    task automatic rd1(input logic [2:0] a, input logic [31:0] exp);
        b1.addr = a;
        @(negedge clk);
        check($sformatf("q1_addr%0d", a), b1.q, exp);
    endtask

    task automatic wait_tick3();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b0.sample_tick && b0.sample_ch == 3'd3) && n < 400);
        if (!(b0.sample_tick && b0.sample_ch == 3'd3)) check("tick3_wait", 0, 1);
    endtask

    task automatic wait_shift();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!b0.cs_n && !b0.sck) && n < 100);
        if (!(!b0.cs_n && !b0.sck)) check("shift_wait", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, f0, t1, c1, c2;
        reset = 1'b1;
        en    = 1'b0;
        b0.addr = '0; b0.ack = 1'b0;
        b1.addr = '0; b1.ack = 1'b0;
        for (int i = 0; i < 8; i++) chan_val[i] = 16'h0A50;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_cs_n",  b0.cs_n, 1);
        check("rst_sck",   b0.sck, 1);
        check("rst_dout",  b0.dout, 0);
        check("rst_q",     b0.q, 0);
        check("rst_chg",   b0.changed, 0);
        check("rst_irq",   b0.irq, 0);
        check("rst_tick",  b0.sample_tick, 0);

        // start scanning
        reset = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        check("cs_first_fall", b0.cs_n, 0);
        repeat (400) @(negedge clk);

        check("ctl_frame0", ctl_log0[0], 16'h0000);
        check("ctl_frame1", ctl_log0[1], 16'h0800);
        check("ctl_frame2_ch", ctl_log0[2][13:11], 3'd2);
        check("sck_pulses", pulse_log0[0], 16);
        check("cs_period", cs_fall0[1] - cs_fall0[0], 37);
        check("tick1_ch", tick_ch[0], 0);
        t1 = tick_cyc[0]; c1 = cs_fall0[1]; c2 = cs_fall0[2];
        check("tick1_in_frame1", (t1 > c1) && (t1 < c2), 1);
        for (int a = 0; a < 8; a++) rd0(3'(a), 32'hA5);
        check("const_nochg", b0.changed, 0);
        check("const_noirq", b0.irq, 0);

        // 3 channels, 12-bit, CLK_DIV=2
        check("n3_addr0", ctl_log1[0][13:11], 3'd0);
        check("n3_addr1", ctl_log1[1][13:11], 3'd1);
        check("n3_addr2", ctl_log1[2][13:11], 3'd2);
        check("n3_addr3", ctl_log1[3][13:11], 3'd0);
        check("n3_period", cs_fall1[1] - cs_fall1[0], 70);
        rd1(3'd0, 32'hFFF);
        rd1(3'd2, 32'hFFF);
        rd1(3'd5, 32'h0);

        // channel 3 step response through the IIR
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chan_val[3] = 16'h0400;
        reset   = 1'b0;
        b0.addr = 3'd3;
        wait_tick3();
        check("seed_nochg", b0.changed[3], 0);
        @(negedge clk);
        check("q3_seed", b0.q, 8'h40);
        chan_val[3] = 16'h0800;
        wait_tick3();
        check("chg3_set", b0.changed[3], 1);
        check("irq_lag", b0.irq, 0);
        @(negedge clk);
        check("irq_set", b0.irq, 1);
        check("q3_w1", b0.q, 8'h50);
        b0.ack = 1'b1;
        @(negedge clk);
        b0.ack = 1'b0;
        check("ack_clr", b0.changed[3], 0);
        @(negedge clk);
        check("irq_clr", b0.irq, 0);
        wait_tick3();
        check("chg3_again", b0.changed[3], 1);
        @(negedge clk);
        check("q3_w2", b0.q, 8'h5C);
        wait_tick3();
        @(negedge clk);
        check("q3_w3", b0.q, 8'h65);

        // drop enable mid-frame: frame finishes, no new frame starts
        wait_shift();
        en = 1'b0;
        t0 = tick_cnt;
        f0 = cs_fall0.size();
        repeat (80) @(negedge clk);
        check("dis_tick", tick_cnt - t0, 1);
        check("dis_no_frame", cs_fall0.size() - f0, 0);
        check("dis_cs_high", b0.cs_n, 1);
        en = 1'b1;
        t0 = tick_cnt;
        repeat (40) @(negedge clk);
        check("prime_notick", tick_cnt - t0, 0);
        repeat (37) @(negedge clk);
        check("post_prime_tick", tick_cnt - t0, 1);

        // reset in the middle of a shift
        check("chg_pre_rst", b0.changed != 0, 1);
        wait_shift();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n", b0.cs_n, 1);
        check("mid_rst_sck",  b0.sck, 1);
        check("mid_rst_dout", b0.dout, 0);
        check("mid_rst_chg",  b0.changed, 0);
        check("mid_rst_irq",  b0.irq, 0);
        en    = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd0(3'(a), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
